// File: rtl/riscv_pkg.sv
// riscv_pkg: basic RISC-V architectural types shared by the fetch stage.
//   XLEN      - architectural address width
//   addr_t    - instruction/data address type
//   ADDR_ZERO - all-zero address constant
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t ADDR_ZERO = {XLEN{1'b0}};

endpackage

// File: rtl/tortoise_pkg.sv
// tortoise_pkg: core-level configuration and types for the tortoise front end.
//   RAS_DEPTH     - number of entries in the return address stack
//   ras_state_e   - states of the RAS sequencer (CLEAR, RUN, OFF)
//   ret_addr_calc - link address of a call: pc + 2 (compressed) or pc + 4
package tortoise_pkg;

  localparam int RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    OFF   = 2'd2
  } ras_state_e;

  // Link address; the sum is taken at address width so a carry out wraps.
  function automatic riscv_pkg::addr_t ret_addr_calc(input riscv_pkg::addr_t pc,
                                                     input logic rvc);
    riscv_pkg::addr_t step;
    step = rvc ? riscv_pkg::addr_t'(2'd2) : riscv_pkg::addr_t'(3'd4);
    return pc + step;
  endfunction

endpackage

// File: rtl/ras_ctrl.sv
// ras_ctrl: sequencer for the fetch-stage return address stack.
// Turns predecoded call/return flags into push/pop/replace/flush commands,
// supplies the predicted return target, tracks stack occupancy and clears
// the stack after reset, flushes and re-enable.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   flush_i, enable_i              pipeline redirect, CSR prediction enable
//   fetch_valid_i / fetch_ready_o  instruction handshake
//   is_call_i, is_ret_i, is_rvc_i  predecoded flags, pc_i instruction address
//   ras_push_o, ras_pop_o, ras_ret_addr_o, ras_flush_o  stack commands
//   ras_valid_i, ras_top_i         stack top
//   pred_valid_o, pred_target_o    return prediction to fetch
//   occupancy_o                    tracked entry count, 0..DEPTH
module ras_ctrl
  import riscv_pkg::*;
  import tortoise_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       enable_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic                       is_call_i,
  input  logic                       is_ret_i,
  input  logic                       is_rvc_i,
  input  addr_t                      pc_i,
  output logic                       ras_push_o,
  output logic                       ras_pop_o,
  output addr_t                      ras_ret_addr_o,
  output logic                       ras_flush_o,
  input  logic                       ras_valid_i,
  input  addr_t                      ras_top_i,
  output logic                       pred_valid_o,
  output addr_t                      pred_target_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1'b1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(DEPTH);

  ras_state_e       state_r;
  ras_state_e       state_s;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] occ_s;
  logic             accept_s;
  logic             ret_ok_s;

  // Next-state, occupancy update and combinational stack commands.
  always_comb begin
    state_s        = state_r;
    occ_s          = occ_r;
    accept_s       = 1'b0;
    ret_ok_s       = 1'b0;
    fetch_ready_o  = 1'b0;
    ras_flush_o    = 1'b0;
    ras_push_o     = 1'b0;
    ras_pop_o      = 1'b0;
    ras_ret_addr_o = ADDR_ZERO;
    pred_valid_o   = 1'b0;
    pred_target_o  = ADDR_ZERO;

    case (state_r)
      CLEAR: begin
        ras_flush_o = 1'b1;
        occ_s       = OCC_ZERO;
        state_s     = enable_i ? RUN : OFF;
      end
      RUN: begin
        // A redirect in flight means this instruction is on the wrong path.
        fetch_ready_o = ~flush_i & ~rst_i;
        accept_s      = fetch_valid_i & fetch_ready_o;
        // Only predict from an entry both the stack and our count agree on.
        ret_ok_s      = is_ret_i & ras_valid_i & (occ_r != OCC_ZERO);
        if (accept_s) begin
          if (is_call_i) begin
            ras_push_o     = 1'b1;
            ras_ret_addr_o = ret_addr_calc(pc_i, is_rvc_i);
          end else begin
            ras_push_o = 1'b0;
          end
          if (ret_ok_s) begin
            ras_pop_o     = 1'b1;
            pred_valid_o  = 1'b1;
            pred_target_o = ras_top_i;
          end else begin
            ras_pop_o = 1'b0;
          end
          // push+pop is a replace: count unchanged. Push saturates because
          // the stack silently drops its oldest entry when full.
          if (is_call_i && !ret_ok_s) begin
            occ_s = (occ_r == OCC_MAX) ? occ_r : occ_r + OCC_ONE;
          end else if (!is_call_i && ret_ok_s) begin
            occ_s = occ_r - OCC_ONE;
          end else begin
            occ_s = occ_r;
          end
        end else begin
          occ_s = occ_r;
        end
        if (!enable_i) begin
          state_s = OFF;
        end else begin
          state_s = RUN;
        end
      end
      OFF: begin
        fetch_ready_o = ~flush_i & ~rst_i;
        // Re-enabling goes through CLEAR so stale entries are discarded.
        if (enable_i) begin
          state_s = CLEAR;
          occ_s   = OCC_ZERO;
        end else begin
          state_s = OFF;
        end
      end
      default: begin
        state_s = CLEAR;
        occ_s   = OCC_ZERO;
      end
    endcase

    // Flush wins over any enable change; counter is zeroed on entry to CLEAR.
    if (flush_i) begin
      state_s = CLEAR;
      occ_s   = OCC_ZERO;
    end else begin
      state_s = state_s;
    end
  end

  // State and occupancy registers with synchronous reset into CLEAR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= CLEAR;
      occ_r   <= OCC_ZERO;
    end else begin
      state_r <= state_s;
      occ_r   <= occ_s;
    end
  end

  assign occupancy_o = occ_r;

endmodule

// File: tb/tb_ras_ctrl.sv
module tb_ras_ctrl;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, flush_i, enable_i, fetch_valid_i;
  logic          is_call_i, is_ret_i, is_rvc_i, ras_valid_i;
  addr_t         pc_i, ras_top_i;
  logic          fetch_ready_o, ras_push_o, ras_pop_o, ras_flush_o, pred_valid_o;
  addr_t         ras_ret_addr_o, pred_target_o;
  logic [OW-1:0] occupancy_o;

  ras_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .enable_i(enable_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .is_call_i(is_call_i), .is_ret_i(is_ret_i), .is_rvc_i(is_rvc_i), .pc_i(pc_i),
    .ras_push_o(ras_push_o), .ras_pop_o(ras_pop_o), .ras_ret_addr_o(ras_ret_addr_o),
    .ras_flush_o(ras_flush_o), .ras_valid_i(ras_valid_i), .ras_top_i(ras_top_i),
    .pred_valid_o(pred_valid_o), .pred_target_o(pred_target_o), .occupancy_o(occupancy_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode flags, entry count and a behavioural stack.
  int    m_occ      = 0;
  bit    m_clearing = 1'b1;
  bit    m_on       = 1'b0;
  addr_t stk[$];
  bit    inj_inv    = 1'b0;

  bit            e_rst, e_ready, e_push, e_pop, e_flush, e_pred;
  addr_t         e_ret_addr, e_target;
  logic [OW-1:0] e_occ;

  // Drive one cycle of inputs, compute expectations, move to the falling edge.
  task automatic apply(input bit r, input bit f, input bit en, input bit fv,
                       input bit c, input bit rt, input bit rvc, input addr_t pc);
    bit can_pop;
    rst_i = r; flush_i = f; enable_i = en; fetch_valid_i = fv;
    is_call_i = c; is_ret_i = rt; is_rvc_i = rvc; pc_i = pc;
    if (stk.size() > 0 && !inj_inv) begin
      ras_valid_i = 1'b1;
      ras_top_i   = stk[stk.size()-1];
    end else begin
      ras_valid_i = 1'b0;
      ras_top_i   = $urandom;
    end
    e_rst = r; e_ready = 1'b0; e_push = 1'b0; e_pop = 1'b0; e_pred = 1'b0;
    e_ret_addr = 32'd0; e_target = 32'd0;
    e_flush = m_clearing;
    e_occ   = OW'(m_occ);
    if (!r && !m_clearing) begin
      e_ready = !f;
      if (m_on && fv && !f) begin
        can_pop = rt && (m_occ > 0) && ras_valid_i;
        e_push  = c;
        if (c) e_ret_addr = pc + (rvc ? 32'd2 : 32'd4);
        e_pop   = can_pop;
        e_pred  = can_pop;
        if (can_pop) e_target = ras_top_i;
      end
    end
    #4;
  endtask

  // Clock edge: advance the stack and the model from the expected commands.
  task automatic tick();
    @(posedge clk);
    if (e_rst || e_flush) stk.delete();
    else if (e_push && e_pop) stk[stk.size()-1] = e_ret_addr;
    else if (e_push) begin
      stk.push_back(e_ret_addr);
      if (stk.size() > DEPTH) void'(stk.pop_front());
    end else if (e_pop) void'(stk.pop_back());

    if (e_rst) begin
      m_clearing = 1'b1; m_occ = 0;
    end else if (m_clearing) begin
      m_clearing = flush_i; m_on = enable_i; m_occ = 0;
    end else begin
      if (e_push && !e_pop) m_occ = (m_occ < DEPTH) ? m_occ + 1 : DEPTH;
      else if (e_pop && !e_push) m_occ = m_occ - 1;
      if (flush_i) begin
        m_clearing = 1'b1; m_occ = 0;
      end else if (m_on && !enable_i) m_on = 1'b0;
      else if (!m_on && enable_i) begin
        m_clearing = 1'b1; m_occ = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 1, 1, 1, 0, 0, 32'h0000_1000);
      checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", fetch_ready_o); end
      checks++; if (ras_push_o !== 1'b0) begin errors++; $display("FAIL rst_push: got %b want 0", ras_push_o); end
      tick();
    end
    apply(0, 0, 1, 0, 0, 0, 0, 32'd0);
    checks++; if (ras_flush_o !== 1'b1) begin errors++; $display("FAIL clear_flush: got %b want 1", ras_flush_o); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b want 0", fetch_ready_o); end
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("FAIL clear_occ: got %0d want 0", occupancy_o); end
    tick();
    apply(0, 0, 1, 0, 0, 0, 0, 32'd0);
    checks++; if (ras_flush_o !== 1'b0) begin errors++; $display("FAIL flush_one_cycle: got %b want 0", ras_flush_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL run_ready: got %b want 1", fetch_ready_o); end
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("FAIL run_occ: got %0d want 0", occupancy_o); end
    tick();
  endtask

  task automatic test_call_ret();
    apply(0, 0, 1, 1, 1, 0, 0, 32'h0000_1000);
    checks++; if (ras_push_o !== 1'b1) begin errors++; $display("FAIL call_push: got %b want 1", ras_push_o); end
    checks++; if (ras_pop_o !== 1'b0) begin errors++; $display("FAIL call_pop: got %b want 0", ras_pop_o); end
    checks++; if (ras_ret_addr_o !== 32'h0000_1004) begin errors++; $display("FAIL call_addr: got %h want 00001004", ras_ret_addr_o); end
    tick();
    apply(0, 0, 1, 1, 0, 1, 0, 32'h0000_2000);
    checks++; if (occupancy_o !== 3'd1) begin errors++; $display("FAIL call_occ: got %0d want 1", occupancy_o); end
    checks++; if (ras_pop_o !== 1'b1) begin errors++; $display("FAIL ret_pop: got %b want 1", ras_pop_o); end
    checks++; if (pred_valid_o !== 1'b1) begin errors++; $display("FAIL ret_pred_valid: got %b want 1", pred_valid_o); end
    checks++; if (pred_target_o !== 32'h0000_1004) begin errors++; $display("FAIL ret_target: got %h want 00001004", pred_target_o); end
    tick();
    apply(0, 0, 1, 0, 0, 0, 0, 32'd0);
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("FAIL ret_occ: got %0d want 0", occupancy_o); end
    tick();
  endtask

  task automatic test_saturation();
    addr_t want;
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 1, 1, 1, 0, 0, 32'h0000_0100 + 32'(i * 4));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      want = 32'h0000_0118 - 32'(i * 4);
      apply(0, 0, 1, 1, 0, 1, 0, 32'h0000_0500);
      if (i == 0) begin
        checks++; if (occupancy_o !== 3'd4) begin errors++; $display("FAIL sat_occ: got %0d want 4", occupancy_o); end
      end
      checks++; if (pred_valid_o !== 1'b1) begin errors++; $display("FAIL sat_pred_valid[%0d]: got %b want 1", i, pred_valid_o); end
      checks++; if (pred_target_o !== want) begin errors++; $display("FAIL sat_target[%0d]: got %h want %h", i, pred_target_o, want); end
      tick();
    end
    apply(0, 0, 1, 1, 0, 1, 0, 32'h0000_0500);
    checks++; if (pred_valid_o !== 1'b0) begin errors++; $display("FAIL empty_pred: got %b want 0", pred_valid_o); end
    checks++; if (ras_pop_o !== 1'b0) begin errors++; $display("FAIL empty_pop: got %b want 0", ras_pop_o); end
    tick();
  endtask

  task automatic test_rvc_wrap();
    apply(0, 0, 1, 1, 1, 0, 1, 32'hFFFF_FFFE);
    checks++; if (ras_ret_addr_o !== 32'h0000_0000) begin errors++; $display("FAIL rvc_wrap_addr: got %h want 00000000", ras_ret_addr_o); end
    tick();
    apply(0, 0, 1, 1, 1, 0, 0, 32'h0000_1FFC);
    tick();
    apply(0, 0, 1, 1, 1, 1, 0, 32'h0000_3000);
    checks++; if (ras_push_o !== 1'b1 || ras_pop_o !== 1'b1) begin errors++; $display("FAIL swap_cmd: got push=%b pop=%b want 1 1", ras_push_o, ras_pop_o); end
    checks++; if (pred_target_o !== 32'h0000_2000) begin errors++; $display("FAIL swap_target: got %h want 00002000", pred_target_o); end
    checks++; if (ras_ret_addr_o !== 32'h0000_3004) begin errors++; $display("FAIL swap_addr: got %h want 00003004", ras_ret_addr_o); end
    tick();
    apply(0, 0, 1, 0, 0, 0, 0, 32'd0);
    checks++; if (occupancy_o !== 3'd2) begin errors++; $display("FAIL swap_occ: got %0d want 2", occupancy_o); end
    tick();
  endtask

  task automatic test_flush();
    apply(0, 0, 1, 1, 1, 0, 0, 32'h0000_6000); tick();
    apply(0, 0, 1, 1, 1, 0, 0, 32'h0000_6010); tick();
    apply(0, 1, 1, 1, 0, 1, 0, 32'h0000_6020);
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", fetch_ready_o); end
    checks++; if (ras_pop_o !== 1'b0) begin errors++; $display("FAIL flush_pop: got %b want 0", ras_pop_o); end
    tick();
    apply(0, 0, 1, 1, 0, 1, 0, 32'h0000_6020);
    checks++; if (ras_flush_o !== 1'b1) begin errors++; $display("FAIL flush_clear: got %b want 1", ras_flush_o); end
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy_o); end
    tick();
    apply(0, 0, 1, 1, 0, 1, 0, 32'h0000_6020);
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL post_flush_ready: got %b want 1", fetch_ready_o); end
    checks++; if (pred_valid_o !== 1'b0) begin errors++; $display("FAIL post_flush_pred: got %b want 0", pred_valid_o); end
    tick();
  endtask

  task automatic test_enable_toggle();
    apply(0, 0, 1, 1, 1, 0, 0, 32'h0000_4000); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 32'd0); tick();
    apply(0, 0, 0, 1, 1, 0, 0, 32'h0000_4100);
    checks++; if (ras_push_o !== 1'b0) begin errors++; $display("FAIL off_push: got %b want 0", ras_push_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL off_ready: got %b want 1", fetch_ready_o); end
    tick();
    apply(0, 0, 1, 0, 0, 0, 0, 32'd0); tick();
    apply(0, 0, 1, 0, 0, 0, 0, 32'd0);
    checks++; if (ras_flush_o !== 1'b1) begin errors++; $display("FAIL reen_clear: got %b want 1", ras_flush_o); end
    checks++; if (occupancy_o !== 3'd0) begin errors++; $display("FAIL reen_occ: got %0d want 0", occupancy_o); end
    tick();
    apply(0, 0, 1, 1, 1, 0, 0, 32'h0000_4200);
    checks++; if (ras_push_o !== 1'b1 || fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reen_run: got push=%b ready=%b want 1 1", ras_push_o, fetch_ready_o); end
    tick();
  endtask

  task automatic test_random();
    bit r, f, en, fv, c, rt, rvc;
    en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) < 1);
      f   = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 4) en = ~en;
      fv  = ($urandom_range(0, 9) < 8);
      c   = ($urandom_range(0, 9) < 4);
      rt  = ($urandom_range(0, 9) < 4);
      rvc = $urandom_range(0, 1);
      inj_inv = ($urandom_range(0, 9) < 1);
      apply(r, f, en, fv, c, rt, rvc, addr_t'($urandom));
      checks++; if (fetch_ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, fetch_ready_o, e_ready); end
      checks++; if (ras_push_o !== e_push) begin errors++; $display("FAIL rnd_push[%0d]: got %b want %b", n, ras_push_o, e_push); end
      checks++; if (ras_pop_o !== e_pop) begin errors++; $display("FAIL rnd_pop[%0d]: got %b want %b", n, ras_pop_o, e_pop); end
      checks++; if (ras_flush_o !== e_flush) begin errors++; $display("FAIL rnd_flush[%0d]: got %b want %b", n, ras_flush_o, e_flush); end
      checks++; if (ras_ret_addr_o !== e_ret_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, ras_ret_addr_o, e_ret_addr); end
      checks++; if (pred_valid_o !== e_pred || pred_target_o !== e_target) begin errors++; $display("FAIL rnd_pred[%0d]: got %b/%h want %b/%h", n, pred_valid_o, pred_target_o, e_pred, e_target); end
      checks++; if (occupancy_o !== e_occ) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", n, occupancy_o, e_occ); end
      tick();
    end
    inj_inv = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; enable_i = 1'b1; fetch_valid_i = 1'b0;
    is_call_i = 1'b0; is_ret_i = 1'b0; is_rvc_i = 1'b0; pc_i = 32'd0;
    ras_valid_i = 1'b0; ras_top_i = 32'd0;
    test_reset();
    test_call_ret();
    test_saturation();
    test_rvc_wrap();
    test_flush();
    test_enable_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
